turn_input_cond: RTL
====================

TURN_INPUT_COND -- requirements
Module: turn_input_cond

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per input (legal 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a level change (5 ms at 10 MHz, legal 2..2^20).
REQ-003 SHALL have port clk, input, 1 bit, single system clock (10 MHz board clock).
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port key_lr_n, input, 1 bit, raw pushbutton, active-low (0 = pressed = left).
REQ-006 SHALL have port sw_hazard, input, 1 bit, raw slide switch, hazard request.
REQ-007 SHALL have port sw_enable, input, 1 bit, raw slide switch, turn-signal enable.
REQ-008 SHALL have port hazard, output, 1 bit, debounced sw_hazard.
REQ-009 SHALL have port signal_en, output, 1 bit, debounced sw_enable.
REQ-010 SHALL have port lr, output, 1 bit, debounced key_lr_n level (0 = left, 1 = right).
REQ-011 SHALL have port lr_press, output, 1 bit, one-cycle pulse on accepted press (lr 1->0).
REQ-012 SHALL have port any_change, output, 1 bit, one-cycle pulse when any of hazard/signal_en/lr changes.

Function
REQ-013 Each of the three channels SHALL pass its raw input through SYNC_STAGES flops before any other logic.
REQ-014 Each channel SHALL run a 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO; the output is 1 in STABLE_HI and PEND_LO.
REQ-015 STABLE_x -> PEND_y when synced input differs from output; counter cleared to 0.
REQ-016 In PEND_y, counter increments each edge while synced input differs from output; input reverting -> back to STABLE_x, counter cleared.
REQ-017 In PEND_y, the edge on which counter would reach DEBOUNCE_CYCLES-1 with input still differing -> STABLE_y, output flips.
REQ-018 Total latency from clean raw edge to output change SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no output change and no pulse.
REQ-020 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL saturate, never wrap.
REQ-021 lr_press SHALL be high for exactly the one cycle after lr goes 1->0; no pulse on release.
REQ-022 any_change SHALL be high for exactly one cycle after any output flips; simultaneous flips on several channels produce one single-cycle pulse.
REQ-023 Channels SHALL be independent; no priority between hazard and signal_en is applied here (downstream FSM owns priority).
REQ-024 All outputs SHALL be registered; no combinational path from raw inputs to outputs.

Reset
REQ-025 On reset assertion, asynchronously: hazard=0, signal_en=0, lr=1, lr_press=0, any_change=0.
REQ-026 Synchronizer flops SHALL reset to idle levels (key 1, switches 0); FSMs to STABLE_LO (hazard, enable) / STABLE_HI (lr); counters 0.
REQ-027 Reset mid-debounce SHALL discard the pending change; after release, a held input requires full SYNC_STAGES + DEBOUNCE_CYCLES again.
REQ-028 No pulse output SHALL assert on the first edge after reset release.

Structure
REQ-029 Channel FSM state encoding and default DEBOUNCE_CYCLES SHALL live in shared package turn_sig_pkg.
REQ-030 One sub-module debounce_ch (sync + FSM + counter, parameterized reset level) SHALL be instantiated three times.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-031 sw_hazard 0->1 held -> hazard=1 exactly 6 edges later, any_change one-cycle pulse, lr_press=0.
REQ-032 key_lr_n low for 3 cycles then high -> lr stays 1, no pulses.
REQ-033 key_lr_n held low -> lr=0 after 6 edges, lr_press and any_change one cycle each; release -> lr=1 after 6 edges, no lr_press.
REQ-034 sw_hazard and sw_enable rise same cycle -> both outputs 1 same edge, single any_change pulse.
REQ-035 sw_enable high, reset asserted at edge 4 for 2 cycles -> signal_en=0 immediately, rises 6 edges after reset release.
REQ-036 sw_enable toggled every 2 cycles for 40 cycles -> signal_en stays 0.

Source files
------------

// File: rtl/turn_sig_pkg.sv
// Shared definitions for the turn-signal input conditioning slice:
// the per-channel debounce FSM encoding and the default debounce length.
package turn_sig_pkg;

    // 5 ms at the 10 MHz board clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } ch_state_t;

endpackage

// File: rtl/debounce_ch.sv
// One input channel: SYNC_STAGES-deep synchronizer followed by a four-state
// debounce FSM with a saturating stability counter and a registered level.
module debounce_ch
    import turn_sig_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic flip,
    output logic fell
);

    localparam int                CNT_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam ch_state_t         RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    ch_state_t              state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            state  <= RESET_STATE;
            cnt    <= '0;
            level  <= RESET_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            state  <= state_next;
            cnt    <= cnt_next;
            level  <= (state_next == STABLE_HI) || (state_next == PEND_LO);
        end
    end

    // The flip happens on the edge where the counter would reach DEBOUNCE_CYCLES-1,
    // so the output moves exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after the raw edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        flip       = 1'b0;
        unique case (state)
            STABLE_LO: begin
                if (synced) begin
                    state_next = PEND_HI;
                    cnt_next   = '0;
                end
            end
            PEND_HI: begin
                if (!synced) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                    flip       = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!synced) begin
                    state_next = PEND_LO;
                    cnt_next   = '0;
                end
            end
            PEND_LO: begin
                if (synced) begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                    flip       = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = RESET_STATE;
                cnt_next   = '0;
            end
        endcase
    end

    assign fell = flip && (state == PEND_LO);

endmodule

// File: rtl/turn_input_cond.sv
// Conditions the raw turn-signal controls: three independent debounced
// channels plus registered press and change pulses for the downstream FSM.
module turn_input_cond
    import turn_sig_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_lr_n,
    input  logic sw_hazard,
    input  logic sw_enable,
    output logic hazard,
    output logic signal_en,
    output logic lr,
    output logic lr_press,
    output logic any_change
);

    logic hazard_flip, enable_flip, lr_flip;
    logic hazard_fell_unused, enable_fell_unused, lr_fell;

    debounce_ch #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b0)
    ) u_hazard (
        .clk  (clk),
        .reset(reset),
        .raw  (sw_hazard),
        .level(hazard),
        .flip (hazard_flip),
        .fell (hazard_fell_unused)
    );

    debounce_ch #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b0)
    ) u_enable (
        .clk  (clk),
        .reset(reset),
        .raw  (sw_enable),
        .level(signal_en),
        .flip (enable_flip),
        .fell (enable_fell_unused)
    );

    // The key idles high (released = right), so this channel resets high
    debounce_ch #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b1)
    ) u_lr (
        .clk  (clk),
        .reset(reset),
        .raw  (key_lr_n),
        .level(lr),
        .flip (lr_flip),
        .fell (lr_fell)
    );

    // Pulses are registered alongside the level flops, so they coincide with the output flip
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_press   <= 1'b0;
            any_change <= 1'b0;
        end else begin
            lr_press   <= lr_fell;
            any_change <= hazard_flip | enable_flip | lr_flip;
        end
    end

endmodule
